// File: rtl/q_emu_sequencer.sv
// Address and MAC-strobe sequencer for the quantum-state emulator: M gate-matrix x
// state-vector products, scratchpad ping-pong between gates, result to the output SRAM.
module q_emu_sequencer #(
    parameter int unsigned MAX_QUBITS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [127:0]      in_rd_data_hdr,
    output logic [ADDR_W-1:0] gate_rd_addr,
    output logic [ADDR_W-1:0] scr_rd_addr,
    output logic              scr_wr_en,
    output logic [ADDR_W-1:0] scr_wr_addr,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic              mac_src_sel,
    output logic              mac_first,
    output logic              mac_acc,
    output logic              mac_last,
    output logic              cfg_err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_RD,
        S_HDR_CAP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [63:0]       hdr_q, hdr_m;
    logic              cfg_bad;
    logic [ADDR_W-1:0] n_cap, nn_cap;

    logic [63:0]       m_reg, g_cnt;
    logic [ADDR_W-1:0] n_reg, nn_reg;
    logic [ADDR_W-1:0] k_cnt, i_cnt, row_base, gate_base;
    logic              drain_cnt;
    logic              k_wrap, i_end, last_gate;

    // Issue-stage values, registered onto the ports one cycle later
    logic [ADDR_W-1:0] iss_in_addr, iss_gate_addr, iss_scr_addr, iss_wr_addr;
    logic              iss_acc, iss_first, iss_last, iss_src, iss_final, iss_cfg_err;

    logic              pa_acc, pa_first, pa_last, pa_src, pa_final;
    logic [ADDR_W-1:0] pa_wr_addr;
    logic              pb_final;
    logic [ADDR_W-1:0] pb_wr_addr;

    assign hdr_q   = in_rd_data_hdr[127:64];
    assign hdr_m   = in_rd_data_hdr[63:0];
    assign cfg_bad = hdr_q > 64'(MAX_QUBITS);
    // Only meaningful when cfg_bad is clear, so a narrow shift amount suffices
    assign n_cap   = ADDR_ONE << hdr_q[7:0];
    assign nn_cap  = ADDR_ONE << {hdr_q[6:0], 1'b0};

    assign k_wrap    = (k_cnt == n_reg - ADDR_ONE);
    assign i_end     = (i_cnt == n_reg - ADDR_ONE);
    assign last_gate = (g_cnt == m_reg - 64'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (dut_valid) state_nxt = S_HDR_RD;
            S_HDR_RD:  state_nxt = S_HDR_CAP;
            S_HDR_CAP: begin
                if (cfg_bad)             state_nxt = S_IDLE;
                else if (hdr_m == '0)    state_nxt = S_DONE;
                else                     state_nxt = S_RUN;
            end
            S_RUN:     if (k_wrap && i_end) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_cnt) state_nxt = last_gate ? S_DONE : S_RUN;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Row and gate bases advance by N and N*N so no multiplier is needed
    always_ff @(posedge clk) begin
        if (reset) begin
            m_reg     <= '0;
            g_cnt     <= '0;
            n_reg     <= '0;
            nn_reg    <= '0;
            k_cnt     <= '0;
            i_cnt     <= '0;
            row_base  <= '0;
            gate_base <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                S_HDR_CAP: begin
                    m_reg     <= hdr_m;
                    n_reg     <= n_cap;
                    nn_reg    <= nn_cap;
                    g_cnt     <= '0;
                    k_cnt     <= '0;
                    i_cnt     <= '0;
                    row_base  <= '0;
                    gate_base <= '0;
                    drain_cnt <= 1'b0;
                end
                S_RUN: begin
                    if (k_wrap) begin
                        k_cnt    <= '0;
                        i_cnt    <= i_cnt + ADDR_ONE;
                        row_base <= row_base + n_reg;
                    end else begin
                        k_cnt <= k_cnt + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    k_cnt     <= '0;
                    i_cnt     <= '0;
                    row_base  <= '0;
                    if (drain_cnt) begin
                        g_cnt     <= g_cnt + 64'd1;
                        gate_base <= gate_base + nn_reg;
                    end
                end
                default: begin
                    drain_cnt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        iss_in_addr   = '0;
        iss_gate_addr = '0;
        iss_scr_addr  = '0;
        iss_acc       = 1'b0;
        iss_first     = 1'b0;
        iss_last      = 1'b0;
        iss_src       = 1'b0;
        iss_final     = last_gate;
        iss_wr_addr   = (last_gate ? '0 : (g_cnt[0] ? n_reg : '0)) + i_cnt;
        iss_cfg_err   = 1'b0;
        case (state)
            S_HDR_CAP: iss_cfg_err = cfg_bad;
            S_RUN: begin
                iss_acc       = 1'b1;
                iss_gate_addr = gate_base + row_base + k_cnt;
                iss_first     = (k_cnt == '0);
                iss_last      = k_wrap;
                iss_src       = (g_cnt != '0);
                // Gate g>0 reads the bank gate g-1 wrote, i.e. the one opposite g's parity
                if (g_cnt == '0) iss_in_addr  = ADDR_ONE + k_cnt;
                else             iss_scr_addr = (g_cnt[0] ? '0 : n_reg) + k_cnt;
            end
            default: ;
        endcase
    end

    // Addresses leave one cycle after issue, strobes one more, row writes one after mac_last
    always_ff @(posedge clk) begin
        if (reset) begin
            dut_ready    <= 1'b1;
            cfg_err      <= 1'b0;
            in_rd_addr   <= '0;
            gate_rd_addr <= '0;
            scr_rd_addr  <= '0;
            pa_acc       <= 1'b0;
            pa_first     <= 1'b0;
            pa_last      <= 1'b0;
            pa_src       <= 1'b0;
            pa_final     <= 1'b0;
            pa_wr_addr   <= '0;
            mac_acc      <= 1'b0;
            mac_first    <= 1'b0;
            mac_last     <= 1'b0;
            mac_src_sel  <= 1'b0;
            pb_final     <= 1'b0;
            pb_wr_addr   <= '0;
            scr_wr_en    <= 1'b0;
            scr_wr_addr  <= '0;
            out_wr_en    <= 1'b0;
            out_wr_addr  <= '0;
        end else begin
            dut_ready    <= (state == S_IDLE);
            cfg_err      <= iss_cfg_err;
            in_rd_addr   <= iss_in_addr;
            gate_rd_addr <= iss_gate_addr;
            scr_rd_addr  <= iss_scr_addr;
            pa_acc       <= iss_acc;
            pa_first     <= iss_first;
            pa_last      <= iss_last;
            pa_src       <= iss_src;
            pa_final     <= iss_final;
            pa_wr_addr   <= iss_wr_addr;
            mac_acc      <= pa_acc;
            mac_first    <= pa_acc & pa_first;
            mac_last     <= pa_acc & pa_last;
            mac_src_sel  <= pa_acc & pa_src;
            pb_final     <= pa_final;
            pb_wr_addr   <= pa_wr_addr;
            scr_wr_en    <= mac_last & ~pb_final;
            scr_wr_addr  <= (mac_last & ~pb_final) ? pb_wr_addr : '0;
            out_wr_en    <= mac_last & pb_final;
            out_wr_addr  <= (mac_last & pb_final) ? pb_wr_addr : '0;
        end
    end

endmodule

// File: tb/tb_q_emu_sequencer.sv
// Scoreboard bench for q_emu_sequencer: expected reads/writes are queued from a
// reference model of each job and popped as the strobes appear.
module tb_q_emu_sequencer;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          dut_valid;
    logic          dut_ready;
    logic [AW-1:0] in_rd_addr;
    logic [127:0]  in_rd_data_hdr;
    logic [AW-1:0] gate_rd_addr;
    logic [AW-1:0] scr_rd_addr;
    logic          scr_wr_en;
    logic [AW-1:0] scr_wr_addr;
    logic          out_wr_en;
    logic [AW-1:0] out_wr_addr;
    logic          mac_src_sel;
    logic          mac_first;
    logic          mac_acc;
    logic          mac_last;
    logic          cfg_err;

    logic [127:0]  hdr_word = '0;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic [AW-1:0] gaddr;
        logic [AW-1:0] iaddr;
        logic [AW-1:0] saddr;
        logic          first;
        logic          last;
        logic          src;
        int            gate;
    } rd_t;

    typedef struct {
        logic          is_out;
        logic [AW-1:0] addr;
        int            gate;
    } wr_t;

    rd_t rq[$];
    wr_t wq[$];
    int  wgate[64];
    int  wcyc[64];

    q_emu_sequencer #(.MAX_QUBITS(4), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .dut_valid      (dut_valid),
        .dut_ready      (dut_ready),
        .in_rd_addr     (in_rd_addr),
        .in_rd_data_hdr (in_rd_data_hdr),
        .gate_rd_addr   (gate_rd_addr),
        .scr_rd_addr    (scr_rd_addr),
        .scr_wr_en      (scr_wr_en),
        .scr_wr_addr    (scr_wr_addr),
        .out_wr_en      (out_wr_en),
        .out_wr_addr    (out_wr_addr),
        .mac_src_sel    (mac_src_sel),
        .mac_first      (mac_first),
        .mac_acc        (mac_acc),
        .mac_last       (mac_last),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read model of q_state_input: header at word 0, filler elsewhere
    always @(posedge clk) begin
        in_rd_data_hdr <= (in_rd_addr == '0) ? hdr_word : {4{32'hA5A5_5A5A}};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        for (int unsigned t = 0; t < 100 && dut_ready !== 1'b1; t++) @(negedge clk);
        total++;
        if (dut_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s wait_ready: got dut_ready=%b want 1", name, dut_ready);
        end
    endtask

    // Full job with scoreboard checking of every read, strobe, write and the latency
    task automatic run_job(input logic [63:0] q, input logic [63:0] m, input string name);
        int unsigned n, lat_exp;
        int          lat;
        logic [AW-1:0] pg, pi, ps;
        logic pml;
        rd_t e;
        wr_t w;
        n = 1 << q;
        lat_exp = 3 + int'(m) * (n * n + 2) + 1;
        rq.delete();
        wq.delete();
        for (int unsigned a = 0; a < 64; a++) begin
            wgate[a] = -5;
            wcyc[a]  = -5;
        end
        for (int unsigned g = 0; g < int'(m); g++) begin
            for (int unsigned i = 0; i < n; i++) begin
                for (int unsigned k = 0; k < n; k++) begin
                    e.gaddr = AW'(g * n * n + i * n + k);
                    e.iaddr = (g == 0) ? AW'(1 + k) : '0;
                    e.saddr = (g == 0) ? '0 : AW'(((g - 1) & 1) * n + k);
                    e.first = (k == 0);
                    e.last  = (k == n - 1);
                    e.src   = (g != 0);
                    e.gate  = int'(g);
                    rq.push_back(e);
                end
                w.is_out = (g == int'(m) - 1);
                w.addr   = w.is_out ? AW'(i) : AW'((g & 1) * n + i);
                w.gate   = int'(g);
                wq.push_back(w);
            end
        end

        wait_ready(name);
        hdr_word  = {q, m};
        dut_valid = 1'b1;
        @(posedge clk);
        lat = -1;
        pg = '0; pi = '0; ps = '0; pml = 1'b0;
        for (int unsigned j = 0; j < lat_exp + 20; j++) begin
            @(negedge clk);
            if (j == 0) dut_valid = 1'b0;
            if (mac_acc === 1'b1) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s extra_read: got mac_acc=1 at cycle %0d want no read", name, j);
                end else begin
                    e = rq.pop_front();
                    total++;
                    if (pg !== e.gaddr) begin
                        bad++;
                        $display("FAIL %s gate_rd_addr: got %0d want %0d", name, pg, e.gaddr);
                    end
                    total++;
                    if ({mac_first, mac_last, mac_src_sel} !== {e.first, e.last, e.src}) begin
                        bad++;
                        $display("FAIL %s mac_strobes(first,last,src): got %b%b%b want %b%b%b",
                                 name, mac_first, mac_last, mac_src_sel, e.first, e.last, e.src);
                    end
                    total++;
                    if (e.src == 1'b0) begin
                        if (pi !== e.iaddr) begin
                            bad++;
                            $display("FAIL %s in_rd_addr: got %0d want %0d", name, pi, e.iaddr);
                        end
                    end else if (ps !== e.saddr) begin
                        bad++;
                        $display("FAIL %s scr_rd_addr: got %0d want %0d", name, ps, e.saddr);
                    end
                    if (e.src == 1'b1) begin
                        total++;
                        if (wgate[e.saddr[5:0]] != e.gate - 1 || wcyc[e.saddr[5:0]] >= int'(j) - 1) begin
                            bad++;
                            $display("FAIL %s scr_raw: addr %0d writer gate %0d at cycle %0d, want gate %0d before cycle %0d",
                                     name, e.saddr, wgate[e.saddr[5:0]], wcyc[e.saddr[5:0]], e.gate - 1, int'(j) - 1);
                        end
                    end
                end
            end else begin
                total++;
                if ({mac_first, mac_last, mac_src_sel} !== 3'b000) begin
                    bad++;
                    $display("FAIL %s idle_strobes: got %b%b%b want 000", name, mac_first, mac_last, mac_src_sel);
                end
            end
            if (scr_wr_en === 1'b1 || out_wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s extra_write: got write at cycle %0d want none", name, j);
                end else begin
                    w = wq.pop_front();
                    total++;
                    if ({out_wr_en, scr_wr_en} !== {w.is_out, ~w.is_out}) begin
                        bad++;
                        $display("FAIL %s wr_dest(out,scr): got %b%b want %b%b", name, out_wr_en, scr_wr_en, w.is_out, ~w.is_out);
                    end
                    total++;
                    if ((w.is_out ? out_wr_addr : scr_wr_addr) !== w.addr) begin
                        bad++;
                        $display("FAIL %s wr_addr: got %0d want %0d", name, w.is_out ? out_wr_addr : scr_wr_addr, w.addr);
                    end
                    total++;
                    if (pml !== 1'b1) begin
                        bad++;
                        $display("FAIL %s wr_timing: got prev mac_last=%b want 1", name, pml);
                    end
                    if (!w.is_out) begin
                        wgate[w.addr[5:0]] = w.gate;
                        wcyc[w.addr[5:0]]  = int'(j);
                    end
                end
            end
            total++;
            if (cfg_err !== 1'b0) begin
                bad++;
                $display("FAIL %s cfg_err: got %b want 0", name, cfg_err);
            end
            if (j == 1) begin
                total++;
                if (dut_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s ready_drop: got %b want 0", name, dut_ready);
                end
            end
            if (j >= 1 && dut_ready === 1'b1) begin
                lat = int'(j);
                break;
            end
            pg  = gate_rd_addr;
            pi  = in_rd_addr;
            ps  = scr_rd_addr;
            pml = mac_last;
        end
        total++;
        if (lat != int'(lat_exp)) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, lat_exp);
        end
        total++;
        if (rq.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL %s missing_ops: got %0d reads %0d writes left want 0 0", name, rq.size(), wq.size());
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        dut_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (dut_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset dut_ready: got %b want 1", dut_ready);
        end
        total++;
        if ({scr_wr_en, out_wr_en, mac_src_sel, mac_first, mac_acc, mac_last, cfg_err} !== 7'b0) begin
            bad++;
            $display("FAIL reset strobes: got %b want 0000000",
                     {scr_wr_en, out_wr_en, mac_src_sel, mac_first, mac_acc, mac_last, cfg_err});
        end
        total++;
        if ({in_rd_addr, gate_rd_addr, scr_rd_addr, scr_wr_addr, out_wr_addr} !== '0) begin
            bad++;
            $display("FAIL reset addrs: got %h %h %h %h %h want all 0",
                     in_rd_addr, gate_rd_addr, scr_rd_addr, scr_wr_addr, out_wr_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_q1_m1();
        run_job(64'd1, 64'd1, "q1_m1");
    endtask

    task automatic test_q1_m3();
        run_job(64'd1, 64'd3, "q1_m3");
    endtask

    task automatic test_q0_m2();
        run_job(64'd0, 64'd2, "q0_m2");
    endtask

    task automatic test_cfg_err();
        int unsigned pulses;
        pulses = 0;
        wait_ready("cfg_err");
        hdr_word  = {64'd5, 64'd1};
        dut_valid = 1'b1;
        @(posedge clk);
        for (int unsigned j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) dut_valid = 1'b0;
            if (cfg_err === 1'b1) pulses++;
            total++;
            if ({mac_acc, scr_wr_en, out_wr_en} !== 3'b000 || gate_rd_addr !== '0 || in_rd_addr !== '0) begin
                bad++;
                $display("FAIL cfg_err no_activity: got acc/scr/out=%b%b%b gate=%0d in=%0d want 000 0 0",
                         mac_acc, scr_wr_en, out_wr_en, gate_rd_addr, in_rd_addr);
            end
            if (j == 2) begin
                total++;
                if (cfg_err !== 1'b1) begin
                    bad++;
                    $display("FAIL cfg_err pulse: got %b want 1", cfg_err);
                end
            end
            if (j == 3) begin
                total++;
                if (dut_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL cfg_err ready: got %b want 1", dut_ready);
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL cfg_err pulse_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        wait_ready("reset_mid");
        hdr_word  = {64'd2, 64'd2};
        dut_valid = 1'b1;
        @(posedge clk);
        for (int unsigned j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 0) dut_valid = 1'b0;
        end
        total++;
        if (mac_acc !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid running: got mac_acc=%b want 1", mac_acc);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (dut_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid dut_ready: got %b want 1", dut_ready);
        end
        total++;
        if ({scr_wr_en, out_wr_en, mac_acc, mac_first, mac_last, mac_src_sel} !== 6'b0 ||
            gate_rd_addr !== '0 || in_rd_addr !== '0 || scr_rd_addr !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: got en/mac=%b gate=%0d in=%0d scr=%0d want all 0",
                     {scr_wr_en, out_wr_en, mac_acc, mac_first, mac_last, mac_src_sel},
                     gate_rd_addr, in_rd_addr, scr_rd_addr);
        end
        reset = 1'b0;
        for (int unsigned j = 0; j < 6; j++) begin
            @(negedge clk);
            total++;
            if ({scr_wr_en, out_wr_en, mac_acc} !== 3'b000) begin
                bad++;
                $display("FAIL reset_mid no_partial: got scr/out/acc=%b%b%b want 000", scr_wr_en, out_wr_en, mac_acc);
            end
        end
        run_job(64'd2, 64'd2, "post_reset");
    endtask

    task automatic test_m0_hold();
        logic exp_rdy [11];
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        wait_ready("m0_hold");
        hdr_word  = {64'd1, 64'd0};
        dut_valid = 1'b1;
        @(posedge clk);
        for (int unsigned j = 0; j < 11; j++) begin
            @(negedge clk);
            if (j == 5) dut_valid = 1'b0;
            total++;
            if (dut_ready !== exp_rdy[j]) begin
                bad++;
                $display("FAIL m0_hold ready[%0d]: got %b want %b", j, dut_ready, exp_rdy[j]);
            end
            total++;
            if ({scr_wr_en, out_wr_en, mac_acc, cfg_err} !== 4'b0000) begin
                bad++;
                $display("FAIL m0_hold no_ops[%0d]: got scr/out/acc/err=%b want 0000", j,
                         {scr_wr_en, out_wr_en, mac_acc, cfg_err});
            end
        end
    endtask

    task automatic test_back_to_back();
        run_job(64'd2, 64'd1, "b2b_q2_m1");
        run_job(64'd0, 64'd1, "b2b_q0_m1");
        run_job(64'd4, 64'd2, "b2b_q4_m2");
        run_job(64'd3, 64'd3, "b2b_q3_m3");
    endtask

    initial begin
        reset          = 1'b1;
        dut_valid      = 1'b0;
        test_reset();
        test_q1_m1();
        test_q1_m3();
        test_q0_m2();
        test_cfg_err();
        test_reset_mid_run();
        test_m0_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
